enum_seq_monitor: RTL and testbench

Receive-side checker for a 2-bit `states_t` enum sequence (`ts0`→`ts1`→`ts2`→`ts0`), of the kind produced by a free-running enum-typed generator FSM. The block samples the observed state stream and locks onto the legal cycle. It reports transition errors and illegal encodings, and keeps a saturating error count. It sits beside the generator in SV-type frontend tests and exercises enum typedefs, enum casts, enum-typed FSM registers and immediate assertions.

---
 rtl/enum_seq_monitor_if.sv | 28 ++
 rtl/enum_seq_monitor.sv | 132 +++++++++++++
 tb/tb_enum_seq_monitor.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/enum_seq_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : enum_seq_monitor_if
// Brief    : Sample stream in, lock/error status out, for enum_seq_monitor.
// Revision : 1.0 - initial release
// ============================================================================
interface enum_seq_monitor_if #(
    parameter int ERR_W = 8
);
    logic             in_valid;
    logic [1:0]       in_state;
    logic             locked;
    logic             err;
    logic             illegal;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       exp_state;

    modport master (
        output in_valid, in_state,
        input  locked, err, illegal, err_count, exp_state
    );

    modport slave (
        input  in_valid, in_state,
        output locked, err, illegal, err_count, exp_state
    );
endinterface
`default_nettype wire

// File: rtl/enum_seq_monitor.sv
`default_nettype none
// ============================================================================
// Module   : enum_seq_monitor
// Brief    : Locks onto the ts0->ts1->ts2 cycle; flags mismatches and ts3.
// Revision : 1.0 - initial release
// ============================================================================
module enum_seq_monitor #(
    parameter int ERR_W    = 8,
    parameter int LOCK_LEN = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    enum_seq_monitor_if.slave bus
);
    localparam int c_cnt_w = $clog2(LOCK_LEN + 1);
    localparam logic [c_cnt_w-1:0] c_lock_len = c_cnt_w'(LOCK_LEN);

    typedef enum logic [1:0] {ts0 = 2'd0, ts1 = 2'd1, ts2 = 2'd2, ts3 = 2'd3} states_t;
    typedef enum logic [1:0] {m_idle = 2'd0, m_sync = 2'd1, m_lock = 2'd2, m_fault = 2'd3} mon_t;

    mon_t               r_mon;
    states_t            r_last;
    logic [c_cnt_w-1:0] r_good_cnt;
    logic               r_locked;
    logic               r_err;
    logic               r_illegal;
    logic [ERR_W-1:0]   r_err_count;

    states_t            w_sample;
    states_t            w_succ;
    states_t            w_exp;
    logic               w_is3;
    logic [c_cnt_w-1:0] w_good_nxt;

    function automatic states_t succ(input states_t s);
        case (s)
            ts0:     return ts1;
            ts1:     return ts2;
            default: return ts0;
        endcase
    endfunction

    assign w_sample   = states_t'(bus.in_state);
    assign w_is3      = (w_sample == ts3);
    assign w_succ     = succ(r_last);
    assign w_exp      = (r_mon == m_idle) ? ts0 : w_succ;
    assign w_good_nxt = r_good_cnt + c_cnt_w'(1);

    assign bus.locked    = r_locked;
    assign bus.err       = r_err;
    assign bus.illegal   = r_illegal;
    assign bus.err_count = r_err_count;
    assign bus.exp_state = w_exp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mon       <= m_idle;
            r_last      <= ts0;
            r_good_cnt  <= '0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
            r_illegal   <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_err     <= 1'b0;
            r_illegal <= 1'b0;
            if (bus.in_valid) begin
                r_illegal <= w_is3;
                case (r_mon)
                    m_idle: begin
                        if (!w_is3) begin
                            r_mon      <= m_sync;
                            r_last     <= w_sample;
                            r_good_cnt <= '0;
                        end
                    end
                    m_sync: begin
                        if (w_is3) begin
                            r_mon <= m_idle;
                        end else if (w_sample == w_succ) begin
                            r_last     <= w_sample;
                            r_good_cnt <= w_good_nxt;
                            if (w_good_nxt == c_lock_len) begin
                                r_mon    <= m_lock;
                                r_locked <= 1'b1;
                            end
                        end else begin
                            // out-of-order sample simply restarts the run
                            r_last     <= w_sample;
                            r_good_cnt <= '0;
                        end
                    end
                    m_lock: begin
                        if (w_sample == w_exp) begin
                            r_last <= w_sample;
                        end else begin
                            r_err    <= 1'b1;
                            r_mon    <= m_fault;
                            r_locked <= 1'b0;
                            if (r_err_count != '1) begin
                                r_err_count <= r_err_count + ERR_W'(1);
                            end
                        end
                    end
                    default: begin
                        if (w_is3) begin
                            r_mon <= m_idle;
                        end else begin
                            r_mon      <= m_sync;
                            r_last     <= w_sample;
                            r_good_cnt <= '0;
                        end
                    end
                endcase
            end
        end
    end

    always @(*) begin
        assert (r_last != ts3);
        assert (m_idle == '0);
        assert (ts0 == '0);
        assert (r_locked == (r_mon == m_lock));
    end

    always @(posedge clk) begin
        if (!rst && !$past(rst)) begin
            assert (r_err_count >= $past(r_err_count));
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_enum_seq_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_enum_seq_monitor
// Brief    : Directed and random checks of enum_seq_monitor at ERR_W 8 and 2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enum_seq_monitor;
    localparam int LOCK_LEN = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    enum_seq_monitor_if #(.ERR_W(8)) bus8 ();
    enum_seq_monitor_if #(.ERR_W(2)) bus2 ();

    enum_seq_monitor #(.ERR_W(8), .LOCK_LEN(LOCK_LEN)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    enum_seq_monitor #(.ERR_W(2), .LOCK_LEN(LOCK_LEN)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference: run = length of the current successor chain of samples.
    bit   m_locked, m_err, m_ill, m_idle;
    int   m_last, m_run, m_cnt;
    logic [1:0]  m_exp;
    logic [12:0] obs8, exp8;
    logic [6:0]  obs2, exp2;

    assign obs8 = {bus8.locked, bus8.err, bus8.illegal, bus8.exp_state, bus8.err_count};
    assign obs2 = {bus2.locked, bus2.err, bus2.illegal, bus2.exp_state, bus2.err_count};

    always_comb begin
        m_exp = m_idle ? 2'd0 : 2'((m_last + 1) % 3);
        exp8  = {m_locked, m_err, m_ill, m_exp, (m_cnt > 255) ? 8'd255 : 8'(m_cnt)};
        exp2  = {m_locked, m_err, m_ill, m_exp, (m_cnt > 3) ? 2'd3 : 2'(m_cnt)};
    end

    // st = {rst, in_valid, in_state}
    task automatic drive(input logic [3:0] st);
        int s;
        rst           = st[3];
        bus8.in_valid = st[2];
        bus8.in_state = st[1:0];
        bus2.in_valid = st[2];
        bus2.in_state = st[1:0];
        @(posedge clk);
        if (st[3]) begin
            m_locked = 0; m_err = 0; m_ill = 0; m_idle = 1;
            m_last = 0; m_run = 0; m_cnt = 0;
        end else begin
            m_err = 0;
            m_ill = 0;
            if (st[2]) begin
                s = int'(st[1:0]);
                m_ill = (s == 3);
                if (m_locked) begin
                    if (s == (m_last + 1) % 3) begin
                        m_last = s;
                    end else begin
                        m_err = 1; m_cnt++; m_locked = 0; m_run = 0;
                    end
                end else if (s == 3) begin
                    m_run = 0; m_idle = 1;
                end else if (m_run > 0 && s == (m_last + 1) % 3) begin
                    m_run++; m_last = s;
                    if (m_run == LOCK_LEN + 1) m_locked = 1;
                end else begin
                    m_run = 1; m_last = s; m_idle = 0;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(4'h8);
            n_cmp++;
            if (obs8 !== 13'h0 || obs2 !== 7'h0) begin
                n_fail++;
                $display("FAIL reset[%0d] got w8=%h w2=%h want 0/0", i, obs8, obs2);
            end
        end
    endtask

    task automatic test_lock_basic();
        logic [3:0] stim[$] = '{4'h4, 4'h5, 4'h6, 4'h4};
        foreach (stim[i]) begin
            drive(stim[i]);
            n_cmp++;
            if (obs8 !== exp8 || obs2 !== exp2) begin
                n_fail++;
                $display("FAIL lock_basic[%0d] got %h/%h want %h/%h", i, obs8, obs2, exp8, exp2);
            end
            n_cmp++;
            if (bus8.locked !== (i >= 2)) begin
                n_fail++;
                $display("FAIL lock_basic_locked[%0d] got %b want %b", i, bus8.locked, (i >= 2));
            end
        end
        n_cmp++;
        if (bus8.exp_state !== 2'd1) begin
            n_fail++;
            $display("FAIL lock_basic_exp got %0d want 1", bus8.exp_state);
        end
    endtask

    task automatic test_mismatch_relock();
        logic [3:0] stim[$] = '{4'h6, 4'h4, 4'h5, 4'h6};
        foreach (stim[i]) begin
            drive(stim[i]);
            n_cmp++;
            if (obs8 !== exp8 || obs2 !== exp2) begin
                n_fail++;
                $display("FAIL mismatch[%0d] got %h/%h want %h/%h", i, obs8, obs2, exp8, exp2);
            end
            if (i == 0) begin
                n_cmp++;
                if ({bus8.err, bus8.locked, bus8.err_count} !== {1'b1, 1'b0, 8'd1}) begin
                    n_fail++;
                    $display("FAIL mismatch_err got err=%b locked=%b cnt=%0d want 1/0/1",
                             bus8.err, bus8.locked, bus8.err_count);
                end
            end
        end
        n_cmp++;
        if (bus8.locked !== 1'b1) begin
            n_fail++;
            $display("FAIL relock got %b want 1", bus8.locked);
        end
    endtask

    task automatic test_ts3_locked();
        logic [3:0] stim[$] = '{4'h7, 4'h7};
        foreach (stim[i]) begin
            drive(stim[i]);
            n_cmp++;
            if (obs8 !== exp8 || obs2 !== exp2) begin
                n_fail++;
                $display("FAIL ts3[%0d] got %h/%h want %h/%h", i, obs8, obs2, exp8, exp2);
            end
        end
        n_cmp++;
        if ({bus8.illegal, bus8.err, bus8.exp_state, bus8.err_count} !== {1'b1, 1'b0, 2'd0, 8'd2}) begin
            n_fail++;
            $display("FAIL ts3_idle got ill=%b err=%b exp=%0d cnt=%0d want 1/0/0/2",
                     bus8.illegal, bus8.err, bus8.exp_state, bus8.err_count);
        end
    endtask

    task automatic test_gaps();
        logic [3:0] stim[$] = '{4'h4, 4'h3, 4'h0, 4'h2, 4'h5, 4'h6};
        foreach (stim[i]) begin
            drive(stim[i]);
            n_cmp++;
            if (obs8 !== exp8 || obs2 !== exp2) begin
                n_fail++;
                $display("FAIL gaps[%0d] got %h/%h want %h/%h", i, obs8, obs2, exp8, exp2);
            end
        end
        n_cmp++;
        if (bus8.locked !== 1'b1) begin
            n_fail++;
            $display("FAIL gaps_locked got %b want 1", bus8.locked);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] stim[$] = '{4'h8, 4'h4, 4'h5, 4'h6};
        int pulses = 0;
        for (int r = 0; r < 5; r++) stim = {stim, 4'h6, 4'h4, 4'h5, 4'h6};
        foreach (stim[i]) begin
            drive(stim[i]);
            if (bus2.err === 1'b1) pulses++;
            n_cmp++;
            if (obs8 !== exp8 || obs2 !== exp2) begin
                n_fail++;
                $display("FAIL sat[%0d] got %h/%h want %h/%h", i, obs8, obs2, exp8, exp2);
            end
        end
        n_cmp++;
        if (pulses != 5 || bus2.err_count !== 2'd3 || bus8.err_count !== 8'd5) begin
            n_fail++;
            $display("FAIL sat_count got pulses=%0d cnt2=%0d cnt8=%0d want 5/3/5",
                     pulses, bus2.err_count, bus8.err_count);
        end
    endtask

    task automatic test_random();
        logic [3:0] st;
        for (int i = 0; i < 600; i++) begin
            st[3] = ($urandom_range(0, 99) < 2);
            st[2] = ($urandom_range(0, 9) < 8);
            st[1:0] = ($urandom_range(0, 9) < 7) ? m_exp : 2'($urandom_range(0, 3));
            drive(st);
            n_cmp++;
            if (obs8 !== exp8 || obs2 !== exp2) begin
                n_fail++;
                $display("FAIL random[%0d] st=%h got %h/%h want %h/%h", i, st, obs8, obs2, exp8, exp2);
            end
        end
    endtask

    task automatic test_reset_midlock();
        logic [3:0] stim[$] = '{4'h8, 4'h4, 4'h5, 4'h6, 4'h6, 4'h4, 4'h5, 4'h6, 4'hF, 4'h0};
        foreach (stim[i]) begin
            drive(stim[i]);
            n_cmp++;
            if (obs8 !== exp8 || obs2 !== exp2) begin
                n_fail++;
                $display("FAIL rst_mid[%0d] got %h/%h want %h/%h", i, obs8, obs2, exp8, exp2);
            end
            if (i == 7) begin
                n_cmp++;
                if (bus8.locked !== 1'b1 || bus8.err_count !== 8'd1) begin
                    n_fail++;
                    $display("FAIL rst_mid_pre got locked=%b cnt=%0d want 1/1", bus8.locked, bus8.err_count);
                end
            end
            if (i >= 8) begin
                n_cmp++;
                if (obs8 !== 13'h0 || obs2 !== 7'h0) begin
                    n_fail++;
                    $display("FAIL rst_mid_clear[%0d] got %h/%h want 0/0", i, obs8, obs2);
                end
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus8.in_valid = 1'b0;
        bus8.in_state = 2'd0;
        bus2.in_valid = 1'b0;
        bus2.in_state = 2'd0;
        test_reset();
        test_lock_basic();
        test_mismatch_relock();
        test_ts3_locked();
        test_gaps();
        test_saturation();
        test_random();
        test_reset_midlock();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
